// File: rtl/rob_tracker.sv
// rob_tracker: in-order reorder buffer that hands out indices, tracks completion and retires from the head.
// Define ROB_FLUSH_EN to add a synchronous flush input that empties the buffer.
module rob_tracker #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 32,
  parameter int CMPL_W   = 6,
  parameter int COMMIT_W = 3,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ROB_FLUSH_EN
  input  logic                    flush,
`endif
  output logic [IDX_W*WIDTH-1:0]  alloc_ids,
  output logic [WIDTH-1:0]        alloc_ready,
  input  logic [WIDTH-1:0]        alloc_valid,
  input  logic [10*WIDTH-1:0]     alloc_old_aliases,
  input  logic [8*WIDTH-1:0]      alloc_arch_regs,
  input  logic [CMPL_W-1:0]       cmplt_valid,
  input  logic [IDX_W*CMPL_W-1:0] cmplt_rob_id,
  output logic [COMMIT_W-1:0]     commit_valid,
  output logic [10*COMMIT_W-1:0]  commit_free_regs,
  output logic [8*COMMIT_W-1:0]   commit_arch_regs,
  output logic [IDX_W:0]          rob_count,
  output logic                    rob_full,
  output logic                    rob_empty
);

  localparam int NW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(COMMIT_W + 1);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d, free_cnt;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [9:0]       old_q  [DEPTH];
  logic [7:0]       arch_q [DEPTH];

  logic [COMMIT_W-1:0]    commit_valid_q, commit_valid_d;
  logic [10*COMMIT_W-1:0] commit_free_q, commit_free_d;
  logic [8*COMMIT_W-1:0]  commit_arch_q, commit_arch_d;

  logic [NW-1:0] n_alloc;
  logic [CW-1:0] n_commit;
  logic          alloc_run, commit_run, flush_w;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Ready is monotonic in rank, so the leading valid&ready run equals the popcount of a legal mask.
  always_comb begin
    free_cnt    = (IDX_W+1)'(DEPTH) - count_q;
    alloc_ids   = '0;
    alloc_ready = '0;
    n_alloc     = '0;
    alloc_run   = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      alloc_ids[(WIDTH-1-k)*IDX_W +: IDX_W] = tail_q + IDX_W'(k);
      alloc_ready[WIDTH-1-k] = free_cnt > (IDX_W+1)'(k);
      if (alloc_run && alloc_valid[WIDTH-1-k] && alloc_ready[WIDTH-1-k]) begin
        n_alloc = n_alloc + NW'(1);
      end else begin
        alloc_run = 1'b0;
      end
    end
  end

  always_comb begin
    n_commit   = '0;
    commit_run = 1'b1;
    for (int s = 0; s < COMMIT_W; s++) begin
      if (commit_run && valid_q[head_q + IDX_W'(s)] && done_q[head_q + IDX_W'(s)] &&
          ((IDX_W+1)'(s) < count_q)) begin
        n_commit = n_commit + CW'(1);
      end else begin
        commit_run = 1'b0;
      end
    end
  end

  assign rob_count        = count_q;
  assign rob_full         = (count_q == (IDX_W+1)'(DEPTH));
  assign rob_empty        = (count_q == '0);
  assign commit_valid     = commit_valid_q;
  assign commit_free_regs = commit_free_q;
  assign commit_arch_regs = commit_arch_q;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    commit_valid_d = '0;
    commit_free_d  = '0;
    commit_arch_d  = '0;
    for (int p = 0; p < CMPL_W; p++) begin
      if (cmplt_valid[p] && valid_q[cmplt_rob_id[p*IDX_W +: IDX_W]]) begin
        done_d[cmplt_rob_id[p*IDX_W +: IDX_W]] = 1'b1;
      end
    end
    for (int s = 0; s < COMMIT_W; s++) begin
      if (s < int'(n_commit)) begin
        valid_d[head_q + IDX_W'(s)]  = 1'b0;
        done_d[head_q + IDX_W'(s)]   = 1'b0;
        commit_valid_d[s]            = 1'b1;
        commit_free_d[10*s +: 10]    = old_q[head_q + IDX_W'(s)];
        commit_arch_d[8*s +: 8]      = arch_q[head_q + IDX_W'(s)];
      end
    end
    // Allocation is applied last so it overrides a completion aimed at the same index.
    for (int k = 0; k < WIDTH; k++) begin
      if (k < int'(n_alloc)) begin
        valid_d[tail_q + IDX_W'(k)] = 1'b1;
        done_d[tail_q + IDX_W'(k)]  = 1'b0;
      end
    end
    head_d  = head_q + IDX_W'(n_commit);
    tail_d  = tail_q + IDX_W'(n_alloc);
    count_d = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_commit);
    if (flush_w) begin
      valid_d        = '0;
      done_d         = '0;
      commit_valid_d = '0;
      commit_free_d  = '0;
      commit_arch_d  = '0;
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      commit_valid_q <= '0;
      commit_free_q  <= '0;
      commit_arch_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_free_q  <= commit_free_d;
      commit_arch_q  <= commit_arch_d;
    end
  end

  // NOTE: payload storage is not reset; it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (k < int'(n_alloc) && !flush_w) begin
        old_q[tail_q + IDX_W'(k)]  <= alloc_old_aliases[10*(WIDTH-1-k) +: 10];
        arch_q[tail_q + IDX_W'(k)] <= alloc_arch_regs[8*(WIDTH-1-k) +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  logic alloc_contig;
  always_comb begin
    alloc_contig = 1'b1;
    for (int k = 1; k < WIDTH; k++) begin
      if (alloc_valid[WIDTH-1-k] && !alloc_valid[WIDTH-k]) alloc_contig = 1'b0;
    end
  end
  a_alloc_contig: assert property (@(posedge clk) disable iff (rst) alloc_contig);
`endif

endmodule

// File: doc/rob_tracker.md
Name: rob_tracker

Overview:
- In-order reorder buffer directly downstream of the rename/decode stage.
- Hands out up to WIDTH ROB indices per cycle and accepts dispatched micro-ops with their arch regs and displaced physical aliases.
- Marks entries done from execution completion ports.
- Retires up to COMMIT_W done entries per cycle from the head. Returns their old aliases on a 6x5-bit bus that the rename stage uses to refill its free pool.

Parameters:
- WIDTH, 4: dispatch slots per cycle.
- DEPTH, 32: ROB entries; power of two; index width IDX_W = log2(DEPTH) = 5.
- CMPL_W, 6: completion ports.
- COMMIT_W, 3: retire slots per cycle; each retires two 5-bit old aliases, so 2*COMMIT_W*5 = 30 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_ids  out  IDX_W*WIDTH  index offered per slot; slot WIDTH-1 = tail, slot WIDTH-1-k = tail+k mod DEPTH.
- alloc_ready  out  WIDTH  slot of rank k (rank 0 = slot WIDTH-1) ready iff free entries > k.
- alloc_valid  in  WIDTH  slots dispatched this cycle; must be contiguous from the MSB.
- alloc_old_aliases  in  10*WIDTH  two displaced physical regs per slot.
- alloc_arch_regs  in  8*WIDTH  two arch dest regs per slot.
- cmplt_valid  in  CMPL_W  completion strobe per port.
- cmplt_rob_id  in  IDX_W*CMPL_W  completed ROB index per port.
- commit_valid  out  COMMIT_W  retire slot valid; bit 0 = oldest.
- commit_free_regs  out  30  old aliases of retired entries; slot s at bits [10s+9:10s]; 0 when slot invalid.
- commit_arch_regs  out  8*COMMIT_W  arch regs of retired entries, for the retirement RAT.
- rob_count  out  IDX_W+1  occupied entries.
- rob_full  out  1  rob_count == DEPTH.
- rob_empty  out  1  rob_count == 0.

Behaviour:
- State:
  - head and tail: IDX_W-bit pointers, wrap mod DEPTH.
  - count: IDX_W+1 bits.
  - Per entry: valid, done, old_aliases[9:0], arch_regs[7:0].
- Reset (async, immediate):
  - head = tail = count = 0; all valid/done = 0.
  - commit_valid = 0, commit_free_regs = 0, commit_arch_regs = 0.
  - alloc_ready = all 1s; rob_empty = 1; rob_full = 0.
  - alloc_ids = {0,1,2,3} (slot 3 = 0).
- alloc_ids, alloc_ready, rob_count, rob_full, rob_empty are combinational from registered state.
- Allocation:
  - n = popcount(alloc_valid & alloc_ready).
  - At the edge, entries tail..tail+n-1 are written: valid = 1, done = 0, payload from the matching slot.
  - tail advances by n.
  - alloc_valid on a non-ready slot is ignored.
  - A non-contiguous mask is a protocol error (assertion in sim); RTL uses only the leading contiguous run.
- alloc_ready uses the pre-commit count, so same-cycle retirement does not free space (conservative; no comb path from done bits).
- Completion:
  - Each valid port sets done on its entry at the edge, if that entry is valid. Otherwise it is ignored.
  - Duplicate ids across ports are harmless.
  - If completion and allocation hit the same index in one cycle, allocation wins (done = 0).
- Commit:
  - c = number of consecutive valid & done entries starting at head, capped at COMMIT_W and at count.
  - Evaluated on registered state, so completion-to-commit latency is at least 1 cycle after the completion edge.
  - At the edge: retired entries get valid = 0; head += c.
  - commit_* outputs are registered with those entries' payloads, oldest in slot 0; unused slots are zeroed.
  - Outputs hold for one cycle only; they are zero the next cycle unless more commits occur.
- count_next = count + n - c. Alloc and commit in the same cycle are both honoured.
- Wrap-around: all index arithmetic is mod DEPTH. A full ROB has head == tail with count == DEPTH.

Optional Feature:
- Macro ROB_FLUSH_EN adds input flush (1 bit).
- When flush = 1 at an edge:
  - head = tail = count = 0; all valid/done cleared.
  - commit outputs zeroed; the same-cycle alloc and commit are suppressed.
  - Flush takes priority over everything except rst.
- Without the macro: no port and no logic.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → commit_valid = 0 and alloc_ids = {0,1,2,3} immediately; alloc_ready = 4'b1111; rob_empty = 1.
- Alloc 4 with old aliases 0x083, 0x0A5, 0x0C7, 0x0E9, then complete ids 0 and 1 on ports 0 and 3 → next edge commit_valid = 3'b011, commit_free_regs = 30'h000A5_083-style packing ({0, 0x0A5, 0x083}), rob_count = 2.
- Out-of-order: complete id 2, wait 3 cycles → no commit; complete ids 0 and 1 → commit_valid = 3'b111 in one cycle; id 3 retires the following cycle after its completion.
- Fill: allocate to rob_count = 30 → alloc_ready = 4'b1100; allocate 2 → rob_full = 1, alloc_ready = 4'b0000; extra alloc_valid ignored.
- Wrap: drive head = tail = 30 via alloc/commit → alloc_ids = {30,31,0,1}; allocate all, complete all → commits retire 30, 31, 0 then 1 in order.
- ROB_FLUSH_EN: 10 entries live, flush with simultaneous alloc and completion → next cycle rob_count = 0, rob_empty = 1, commit_valid = 0.
